// File: rtl/vita49_trig_pkg.sv
// ----------------------------------------------------------------------------
// vita49_trig_pkg
//   Shared definitions for the VITA-49 trigger scheduler:
//   - TS_W         : width of a full timestamp {tsi[31:0], tsf[63:0]}
//   - trig_state_e : scheduler FSM state encoding (also exported for debug)
//   - win_t        : one queued trigger window (start / stop timestamps)
// ----------------------------------------------------------------------------
package vita49_trig_pkg;

  localparam int TS_W = 96;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } trig_state_e;

  typedef struct packed {
    logic [TS_W-1:0] t_on;
    logic [TS_W-1:0] t_off;
  } win_t;

endpackage

// File: rtl/vita49_trig_sched_fifo.sv
// ----------------------------------------------------------------------------
// vita49_trig_sched_fifo
//   Window queue: C_DEPTH entries of win_t (192 bits), first-word-fall-through.
//   Ports:
//     i_clk, i_rst_n : clock, async active-low reset
//     i_flush        : empties the queue (wins over push/pop)
//     i_push, i_din  : write one window (ignored when full)
//     i_pop          : retire the head window (ignored when empty)
//     o_head         : current head window
//     o_level        : occupancy, 0..C_DEPTH
// ----------------------------------------------------------------------------
module vita49_trig_sched_fifo
  import vita49_trig_pkg::*;
#(
  parameter int C_DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  win_t                     i_din,
  output win_t                     o_head,
  output logic [$clog2(C_DEPTH):0] o_level
);

  localparam int AW = $clog2(C_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(C_DEPTH);

  win_t            r_mem [C_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            w_push;
  logic            w_pop;

  assign w_push  = i_push && (r_level != LVL_FULL);
  assign w_pop   = i_pop  && (r_level != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read once it has been written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/vita49_trig_sched.sv
// ----------------------------------------------------------------------------
// vita49_trig_sched
//   Timestamp-driven AXI-Stream gate. Trigger windows {on, off} are queued and
//   executed in load order; while a window is active the input stream is passed
//   to the output, aligned to packet boundaries.
//   Ports:
//     AXIS_ACLK / AXIS_ARESETN : clock, async active-low reset
//     enable, flush            : arm scheduler / empty queue and close gate
//     win_* + win_valid/ready  : window load handshake
//     tsi, tsf                 : current time {tsi, tsf}
//     S_AXIS_*, M_AXIS_*       : input / output stream
//     trig, win_level          : window active / queue occupancy
//     win_done, win_late       : one-cycle retire pulses (normal / discarded)
//     dbg_state                : FSM state
//   Handshake rule: a transfer happens on a rising edge where valid && ready;
//   valid never depends on ready of the same interface.
// ----------------------------------------------------------------------------
module vita49_trig_sched
  import vita49_trig_pkg::*;
#(
  parameter int C_AXIS_TDATA_NUM_BYTES = 4,
  parameter int C_DEPTH                = 4,
  parameter int C_HOLD_MODE            = 0
) (
  input  logic                                  AXIS_ACLK,
  input  logic                                  AXIS_ARESETN,
  input  logic                                  enable,
  input  logic                                  flush,
  input  logic [31:0]                           win_tsi_on,
  input  logic [31:0]                           win_tsi_off,
  input  logic [63:0]                           win_tsf_on,
  input  logic [63:0]                           win_tsf_off,
  input  logic                                  win_valid,
  output logic                                  win_ready,
  input  logic [31:0]                           tsi,
  input  logic [63:0]                           tsf,
  input  logic [8*C_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_NUM_BYTES-1:0]     S_AXIS_TSTRB,
  input  logic                                  S_AXIS_TLAST,
  input  logic                                  S_AXIS_TVALID,
  output logic                                  S_AXIS_TREADY,
  output logic [8*C_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_NUM_BYTES-1:0]     M_AXIS_TSTRB,
  output logic                                  M_AXIS_TLAST,
  output logic                                  M_AXIS_TVALID,
  input  logic                                  M_AXIS_TREADY,
  output logic                                  trig,
  output logic [$clog2(C_DEPTH):0]              win_level,
  output logic                                  win_done,
  output logic                                  win_late,
  output trig_state_e                           dbg_state
);

  localparam int LW = $clog2(C_DEPTH) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(C_DEPTH);

  trig_state_e     r_state;
  logic            r_trig;
  logic            r_done;
  logic            r_late;
  logic            r_pkt_mid;   // input stream is between first beat and TLAST
  logic            r_skip;      // window began mid-packet: drop rest of that packet

  win_t            w_din;
  win_t            w_head;
  logic [TS_W-1:0] w_now;
  logic [LW-1:0]   w_level;
  logic            w_load;
  logic            w_gate_open;
  logic            w_s_hs;
  logic            w_pkt_mid_nxt;
  logic            w_ge_on;
  logic            w_ge_off;
  logic            w_bad_win;
  logic            w_retire_late;
  logic            w_retire_done;
  logic            w_to_active;
  logic            w_to_drain;
  logic            w_pop;

  assign w_now       = {tsi, tsf};
  assign w_din.t_on  = {win_tsi_on, win_tsf_on};
  assign w_din.t_off = {win_tsi_off, win_tsf_off};

  assign win_ready = (w_level < LVL_FULL) && !flush;
  assign w_load    = win_valid && win_ready;
  assign win_level = w_level;

  vita49_trig_sched_fifo #(
    .C_DEPTH (C_DEPTH)
  ) u_fifo (
    .i_clk   (AXIS_ACLK),
    .i_rst_n (AXIS_ARESETN),
    .i_flush (flush),
    .i_push  (w_load),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_level (w_level)
  );

  // Stream gate
  assign w_gate_open   = ((r_state == ST_ACTIVE) || (r_state == ST_DRAIN)) && !r_skip;
  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TSTRB  = S_AXIS_TSTRB;
  assign M_AXIS_TLAST  = S_AXIS_TLAST;
  assign M_AXIS_TVALID = w_gate_open && S_AXIS_TVALID;
  // A skipped remainder is always consumed, even in hold mode: holding it would
  // stall the stream forever since the gate only opens at a packet boundary.
  assign S_AXIS_TREADY = w_gate_open ? M_AXIS_TREADY : (r_skip || (C_HOLD_MODE == 0));

  assign w_s_hs        = S_AXIS_TVALID && S_AXIS_TREADY;
  // Packet state after this edge; with the gate open this is also the output side.
  assign w_pkt_mid_nxt = w_s_hs ? !S_AXIS_TLAST : r_pkt_mid;

  // Window decisions on the head entry, unsigned 96-bit
  assign w_ge_on       = w_now >= w_head.t_on;
  assign w_ge_off      = w_now >= w_head.t_off;
  assign w_bad_win     = w_head.t_off <= w_head.t_on;
  assign w_retire_late = (r_state == ST_ARMED) && (w_ge_off || w_bad_win);
  assign w_to_active   = (r_state == ST_ARMED) && !w_retire_late && w_ge_on;
  assign w_to_drain    = (r_state == ST_ACTIVE) && w_ge_off && w_gate_open && w_pkt_mid_nxt;
  assign w_retire_done = ((r_state == ST_ACTIVE) && w_ge_off && !w_to_drain) ||
                         ((r_state == ST_DRAIN) && !w_pkt_mid_nxt);
  assign w_pop         = !flush && (w_retire_late || w_retire_done);

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_state   <= ST_IDLE;
      r_trig    <= 1'b0;
      r_done    <= 1'b0;
      r_late    <= 1'b0;
      r_pkt_mid <= 1'b0;
      r_skip    <= 1'b0;
    end else begin
      r_pkt_mid <= w_pkt_mid_nxt;
      r_done    <= 1'b0;
      r_late    <= 1'b0;
      if (flush) begin
        r_state <= ST_IDLE;
        r_trig  <= 1'b0;
        r_skip  <= 1'b0;
      end else begin
        if (!w_pkt_mid_nxt) r_skip <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (enable && (w_level != '0)) r_state <= ST_ARMED;
          end
          ST_ARMED: begin
            if (w_retire_late) begin
              r_state <= ST_IDLE;
              r_late  <= 1'b1;
            end else if (w_to_active) begin
              r_state <= ST_ACTIVE;
              r_trig  <= 1'b1;
              r_skip  <= w_pkt_mid_nxt;
            end
          end
          ST_ACTIVE: begin
            if (w_to_drain) begin
              r_state <= ST_DRAIN;
            end else if (w_retire_done) begin
              r_state <= ST_IDLE;
              r_trig  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (w_retire_done) begin
              r_state <= ST_IDLE;
              r_trig  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign trig      = r_trig;
  assign win_done  = r_done;
  assign win_late  = r_late;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_vita49_trig_sched.sv
module tb_vita49_trig_sched;
  import vita49_trig_pkg::*;

  localparam int NB = 4;
  localparam int DW = 8 * NB;
  localparam int BW = DW + NB + 1;
  localparam int LW = 3;
  localparam logic [1:0] EVT_DONE = 2'b01;
  localparam logic [1:0] EVT_LATE = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          enable = 1'b0, flush = 1'b0;
  logic [31:0]   win_tsi_on = '0, win_tsi_off = '0;
  logic [63:0]   win_tsf_on = '0, win_tsf_off = '0;
  logic          win_valid = 1'b0;
  logic          win_ready;
  logic [31:0]   tsi = '0;
  logic [63:0]   tsf = '0;
  logic [DW-1:0] s_tdata = '0;
  logic [NB-1:0] s_tstrb = '0;
  logic          s_tlast = 1'b0, s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [NB-1:0] m_tstrb;
  logic          m_tlast, m_tvalid;
  logic          m_tready = 1'b1;
  logic          trig;
  logic [LW-1:0] win_level;
  logic          win_done, win_late;
  trig_state_e   dbg_state;

  // hold-mode instance outputs
  logic          h_win_ready, h_s_tready, h_m_tlast, h_m_tvalid, h_trig, h_done, h_late;
  logic [DW-1:0] h_m_tdata;
  logic [NB-1:0] h_m_tstrb;
  logic [LW-1:0] h_level;
  trig_state_e   h_state;

  vita49_trig_sched #(.C_AXIS_TDATA_NUM_BYTES(NB), .C_DEPTH(4), .C_HOLD_MODE(0)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .enable(enable), .flush(flush),
    .win_tsi_on(win_tsi_on), .win_tsi_off(win_tsi_off),
    .win_tsf_on(win_tsf_on), .win_tsf_off(win_tsf_off),
    .win_valid(win_valid), .win_ready(win_ready), .tsi(tsi), .tsf(tsf),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
    .trig(trig), .win_level(win_level), .win_done(win_done), .win_late(win_late),
    .dbg_state(dbg_state)
  );

  vita49_trig_sched #(.C_AXIS_TDATA_NUM_BYTES(NB), .C_DEPTH(4), .C_HOLD_MODE(1)) dut_hold (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .enable(enable), .flush(flush),
    .win_tsi_on(win_tsi_on), .win_tsi_off(win_tsi_off),
    .win_tsf_on(win_tsf_on), .win_tsf_off(win_tsf_off),
    .win_valid(win_valid), .win_ready(h_win_ready), .tsi(tsi), .tsf(tsf),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(h_s_tready),
    .M_AXIS_TDATA(h_m_tdata), .M_AXIS_TSTRB(h_m_tstrb), .M_AXIS_TLAST(h_m_tlast),
    .M_AXIS_TVALID(h_m_tvalid), .M_AXIS_TREADY(m_tready),
    .trig(h_trig), .win_level(h_level), .win_done(h_done), .win_late(h_late),
    .dbg_state(h_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [1:0]    exp_evt_q[$];
  logic [BW-1:0] got_b, exp_b;
  logic [1:0]    got_e, exp_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: output beats and retire pulses, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        got_b = {m_tlast, m_tstrb, m_tdata};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL m_beat: got %0h expected no beat", got_b);
        end else begin
          exp_b = exp_q.pop_front();
          if (got_b !== exp_b) begin
            n_errors++;
            $display("FAIL m_beat: got %0h expected %0h", got_b, exp_b);
          end
        end
      end
      if (win_done || win_late) begin
        got_e = {win_late, win_done};
        n_checks++;
        if (exp_evt_q.size() == 0) begin
          n_errors++;
          $display("FAIL retire_evt: got %0b expected no pulse", got_e);
        end else begin
          exp_e = exp_evt_q.pop_front();
          if (got_e !== exp_e) begin
            n_errors++;
            $display("FAIL retire_evt: got %0b expected %0b", got_e, exp_e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_win(input logic [31:0] on_s, input logic [31:0] off_s);
    win_tsi_on  = on_s;
    win_tsi_off = off_s;
    win_tsf_on  = '0;
    win_tsf_off = '0;
    win_valid   = 1'b1;
    tick(1);
    win_valid   = 1'b0;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [DW-1:0] d, input logic [NB-1:0] st, input logic l);
    int budget;
    budget   = 50;
    s_tdata  = d;
    s_tstrb  = st;
    s_tlast  = l;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      budget--;
      if (budget == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_beat: got no s_tready expected accept within 50 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic exp_trig [6];
    exp_trig = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset values
    tick(2);
    chk("rst_trig", trig, 0);
    chk("rst_level", win_level, 0);
    chk("rst_done", win_done, 0);
    chk("rst_late", win_late, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick(1);

    // Closed gate: drop mode consumes, hold mode backpressures
    s_tdata = 32'h1111_0000; s_tstrb = 4'hF; s_tlast = 1'b1; s_tvalid = 1'b1;
    #1;
    chk("closed_drop_tready", s_tready, 1);
    chk("closed_drop_m_tvalid", m_tvalid, 0);
    chk("closed_hold_tready", h_s_tready, 0);
    tick(1);
    s_tvalid = 1'b0;

    // Window on=10 off=12, sweep tsi 8..13
    enable = 1'b1;
    tsi = 32'd0;
    load_win(32'd10, 32'd12);
    chk("sweep_level_load", win_level, 1);
    exp_evt_q.push_back(EVT_DONE);
    for (int t = 8; t <= 13; t++) begin
      tsi = t;
      tick(1);
      chk($sformatf("sweep_trig_tsi%0d", t), trig, exp_trig[t-8]);
    end
    chk("sweep_level_end", win_level, 0);

    // Late window on=5 off=6 at tsi=7
    tsi = 32'd7;
    exp_evt_q.push_back(EVT_LATE);
    load_win(32'd5, 32'd6);
    chk("late_level_1", win_level, 1);
    tick(1);
    chk("late_trig_a", trig, 0);
    tick(1);
    chk("late_trig_b", trig, 0);
    chk("late_level_0", win_level, 0);

    // Queue full and simultaneous load/pop
    enable = 1'b0;
    win_tsi_on = 32'd100; win_tsi_off = 32'd200; win_tsf_on = '0; win_tsf_off = '0;
    win_valid = 1'b1;
    tick(4);
    chk("full_level", win_level, 4);
    chk("full_ready", win_ready, 0);
    tick(1);
    chk("full_5th_level", win_level, 4);
    win_valid = 1'b0;
    for (int i = 0; i < 5; i++) exp_evt_q.push_back(EVT_LATE);
    enable = 1'b1;
    tsi = 32'd300;
    tick(1);
    chk("full_armed_level", win_level, 4);
    tick(1);
    chk("full_pop_level", win_level, 3);
    tick(1);
    chk("full_rearm_level", win_level, 3);
    win_valid = 1'b1;
    tick(1);
    win_valid = 1'b0;
    chk("pop_load_level", win_level, 3);
    for (int i = 0; i < 20 && win_level != 0; i++) tick(1);
    chk("full_drain_level", win_level, 0);

    // Window closes at beat 3 of an 8-beat packet
    tsi = 32'd15;
    load_win(32'd20, 32'd22);
    tick(1);
    tsi = 32'd20;
    tick(1);
    chk("drain_trig_on", trig, 1);
    chk("drain_state_active", dbg_state, ST_ACTIVE);
    tsi = 32'd21;
    exp_evt_q.push_back(EVT_DONE);
    for (int i = 0; i < 8; i++) begin
      logic [NB-1:0] st;
      st = (i == 7) ? 4'h3 : 4'hF;
      if (i == 3) tsi = 32'd22;
      exp_q.push_back({(i == 7), st, 32'hA000_0000 + i});
      send_beat(32'hA000_0000 + i, st, (i == 7));
      if (i < 3) chk($sformatf("drain_state_b%0d", i), dbg_state, ST_ACTIVE);
      else if (i < 7) chk($sformatf("drain_state_b%0d", i), dbg_state, ST_DRAIN);
      else chk("drain_state_end", dbg_state, ST_IDLE);
      chk($sformatf("drain_trig_b%0d", i), trig, (i < 7));
    end

    // Window starts mid-packet: remainder dropped, next packet passes
    tsi = 32'd25;
    load_win(32'd30, 32'd40);
    tick(1);
    s_tdata = 32'hB000_0000; s_tstrb = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b1;
    #1;
    chk("mid_closed_tready", s_tready, 1);
    chk("mid_closed_hold_tready", h_s_tready, 0);
    tick(1);
    s_tvalid = 1'b0;
    tsi = 32'd30;
    tick(1);
    chk("mid_trig", trig, 1);
    s_tdata = 32'hB000_0001; s_tlast = 1'b1; s_tvalid = 1'b1;
    #1;
    chk("mid_skip_m_tvalid", m_tvalid, 0);
    chk("mid_skip_tready", s_tready, 1);
    tick(1);
    s_tvalid = 1'b0;
    exp_q.push_back({1'b0, 4'hF, 32'hC000_0000});
    exp_q.push_back({1'b1, 4'hF, 32'hC000_0001});
    send_beat(32'hC000_0000, 4'hF, 1'b0);
    send_beat(32'hC000_0001, 4'hF, 1'b1);
    exp_evt_q.push_back(EVT_DONE);
    tsi = 32'd40;
    tick(1);
    chk("mid_trig_off", trig, 0);

    // Flush while ACTIVE with 3 queued
    tsi = 32'd45;
    load_win(32'd50, 32'd60);
    load_win(32'd50, 32'd60);
    load_win(32'd50, 32'd60);
    chk("flush_level_3", win_level, 3);
    tsi = 32'd50;
    tick(1);
    chk("flush_active", dbg_state, ST_ACTIVE);
    exp_q.push_back({1'b0, 4'hF, 32'hD000_0000});
    send_beat(32'hD000_0000, 4'hF, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_win_ready", win_ready, 0);
    tick(1);
    flush = 1'b0;
    chk("flush_state", dbg_state, ST_IDLE);
    chk("flush_trig", trig, 0);
    chk("flush_level", win_level, 0);
    s_tdata = 32'hD000_0001; s_tlast = 1'b1; s_tvalid = 1'b1;
    #1;
    chk("flush_m_tvalid", m_tvalid, 0);
    tick(1);
    s_tvalid = 1'b0;

    // Reset mid-packet
    tsi = 32'd65;
    load_win(32'd70, 32'd80);
    tick(1);
    tsi = 32'd70;
    tick(1);
    exp_q.push_back({1'b0, 4'hF, 32'hE000_0000});
    send_beat(32'hE000_0000, 4'hF, 1'b0);
    s_tdata = 32'hE000_0001; s_tlast = 1'b0; s_tvalid = 1'b1;
    #1;
    chk("rst2_m_tvalid_before", m_tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst2_m_tvalid", m_tvalid, 0);
    chk("rst2_trig", trig, 0);
    chk("rst2_level", win_level, 0);
    chk("rst2_done", win_done, 0);
    chk("rst2_late", win_late, 0);
    chk("rst2_state", dbg_state, ST_IDLE);
    tick(2);
    s_tvalid = 1'b0;
    rst_n = 1'b1;
    tick(2);

    chk("beat_queue_empty", exp_q.size(), 0);
    chk("evt_queue_empty", exp_evt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
